// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the write arbiter and the
// write port of the downstream fifo. The master modport is the arbiter's view;
// the slave modport is the producer/fifo side.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic                      fifo_full;
    logic                      fifo_write;
    logic [DATA_W-1:0]         fifo_data_in;
    logic                      busy;

    modport master (
        input  req, req_data, fifo_full,
        output gnt, ack, fifo_write, fifo_data_in, busy
    );

    modport slave (
        output req, req_data, fifo_full,
        input  gnt, ack, fifo_write, fifo_data_in, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a fifo write port. One producer owns
// the port for a burst of up to MAX_BURST accepted words; the owner's data is
// muxed combinationally onto fifo_data_in and written only when not full.
// Optional build macro FIFO_ARB_STATS_EN adds saturating per-producer word
// counters and a full-stall cycle counter.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef FIFO_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]  stat_words,
    output logic [15:0]            stat_stall,
`endif
    fifo_wr_arbiter_if.master      bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BC_W  = $clog2(MAX_BURST) + 1;
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   own_q, own_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [BC_W-1:0]    bc_q, bc_d;

    logic [NUM_REQ-1:0] ack;
    logic               accept;
    logic               own_req;
    logic               burst_end;
    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    logic               grant_new;
    logic [DATA_W-1:0]  own_data;

    // Accept path: the fifo write strobe and data follow req/full in-cycle
    assign ack       = gnt_q & bus.req & {NUM_REQ{~bus.fifo_full}};
    assign accept    = |ack;
    assign own_req   = bus.req[own_q];
    assign own_data  = bus.req_data[int'(own_q)*DATA_W +: DATA_W];
    assign burst_end = (accept && (bc_q == BC_LAST)) || !own_req;

    assign bus.ack          = ack;
    assign bus.fifo_write   = accept;
    assign bus.fifo_data_in = (|gnt_q) ? own_data : '0;
    assign bus.gnt          = gnt_q;
    assign bus.busy         = (state_q == BURST);

    // Round-robin search: first requester at or after rr_ptr, wrapping
    always_comb begin : arb_search
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        // Walk backwards so the entry closest to rr_ptr is the one left standing
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (bus.req[idx]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    // Next-state: grant on idle request or burst end, otherwise count beats
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        own_d     = own_q;
        rr_d      = rr_q;
        bc_d      = bc_q;
        grant_new = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_new = 1'b1;
                end
            end
            BURST: begin
                if (burst_end) begin
                    if (win_vld) begin
                        grant_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        bc_d    = '0;
                    end
                end else if (accept) begin
                    bc_d = bc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                bc_d    = '0;
            end
        endcase

        // Pointer moves past the new owner so it is served last next round
        if (grant_new) begin
            state_d = BURST;
            own_d   = win_idx;
            gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            rr_d    = (win_idx == PTR_TOP) ? '0 : win_idx + 1'b1;
            bc_d    = '0;
        end
    end

    // State register for arbiter control
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            rr_q    <= '0;
            bc_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            rr_q    <= rr_d;
            bc_q    <= bc_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] words_q [NUM_REQ];
    logic [15:0] stall_q;

    // Saturating activity counters: accepted words per producer, full stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                words_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i]) begin
                    words_q[i] <= sat_inc(words_q[i]);
                end
            end
            if ((|gnt_q) && own_req && bus.fifo_full) begin
                stall_q <= sat_inc(stall_q);
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_words[g*16 +: 16] = words_q[g];
    end
    assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table covering
// reset, round-robin order and early release, then hand-written sequences for
// full stall, single requester and reset in the middle of a burst.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] stat_words;
    logic [15:0]           stat_stall;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef FIFO_ARB_STATS_EN
        .stat_words(stat_words),
        .stat_stall(stat_stall),
`endif
        .bus       (bus)
    );

    typedef struct {
        logic       r;
        logic [3:0] req;
        logic       full;
        logic [3:0] eg;
        logic [3:0] ea;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(input logic r, input logic [3:0] req, input logic full,
                                input logic [3:0] eg, input logic [3:0] ea);
        vec_t v;
        v.r = r; v.req = req; v.full = full; v.eg = eg; v.ea = ea;
        tbl.push_back(v);
    endfunction

    // Drive one cycle's inputs after the falling edge, settle, then sample
    task automatic step(input logic r, input logic [3:0] req, input logic full);
        @(negedge clk);
        rst           = r;
        bus.req       = req;
        bus.fifo_full = full;
        #2;
    endtask

    task automatic check_out(input string name, input logic [3:0] eg, input logic [3:0] ea);
        logic [15:0] ed;
        logic        ew;
        logic        eb;
        ed = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (eg[i]) ed = 16'h1000 + 16'(i);
        end
        ew = |ea;
        eb = |eg;
        checks++;
        if (bus.gnt !== eg || bus.ack !== ea || bus.fifo_write !== ew ||
            bus.fifo_data_in !== ed || bus.busy !== eb) begin
            errors++;
            $display("FAIL %s: got gnt=%b ack=%b wr=%b data=%h busy=%b, want gnt=%b ack=%b wr=%b data=%h busy=%b",
                     name, bus.gnt, bus.ack, bus.fifo_write, bus.fifo_data_in, bus.busy,
                     eg, ea, ew, ed, eb);
        end
        checks++;
        if (bus.fifo_write === 1'b1 && bus.fifo_full === 1'b1) begin
            errors++;
            $display("FAIL %s_write_while_full: got fifo_write=1 with fifo_full=1, want 0", name);
        end
    endtask

    initial begin
        int cnt;
        int words;
        int acks;

        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_data[i*DATA_W +: DATA_W] = 16'h1000 + 16'(i);
        end
        rst           = 1'b1;
        bus.req       = 4'h0;
        bus.fifo_full = 1'b0;

        // Reset held with all producers requesting, then round-robin 4x4 beats
        add(1, 4'hF, 0, 4'h0, 4'h0);
        add(1, 4'hF, 0, 4'h0, 4'h0);
        add(0, 4'hF, 0, 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) add(0, 4'hF, 0, 4'h1, 4'h1);
        for (int k = 0; k < 4; k++) add(0, 4'hF, 0, 4'h2, 4'h2);
        for (int k = 0; k < 4; k++) add(0, 4'hF, 0, 4'h4, 4'h4);
        for (int k = 0; k < 4; k++) add(0, 4'hF, 0, 4'h8, 4'h8);
        // Producer 0 re-granted, then everyone drops -> idle
        add(0, 4'h0, 0, 4'h1, 4'h0);
        // Early release: producer 1 two beats, drops, producer 3 takes over
        add(0, 4'hA, 0, 4'h0, 4'h0);
        add(0, 4'hA, 0, 4'h2, 4'h2);
        add(0, 4'hA, 0, 4'h2, 4'h2);
        add(0, 4'h8, 0, 4'h2, 4'h0);
        for (int k = 0; k < 4; k++) add(0, 4'h8, 0, 4'h8, 4'h8);
        add(0, 4'h0, 0, 4'h8, 4'h0);
        add(0, 4'h0, 0, 4'h0, 4'h0);

        // Unchecked first reset edge so state is defined before the table
        step(1, 4'hF, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].req, tbl[i].full);
            check_out($sformatf("vec%0d", i), tbl[i].eg, tbl[i].ea);
        end

        // Full stall: producer 2 fills a 16-entry fifo, then one read frees a slot
        cnt = 0;
        step(0, 4'h4, 0);
        check_out("stall_idle", 4'h0, 4'h0);
        for (int k = 0; k < 16; k++) begin
            step(0, 4'h4, cnt == 16);
            check_out($sformatf("stall_fill%0d", k), 4'h4, 4'h4);
            if (bus.fifo_write === 1'b1) cnt++;
        end
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            step(0, 4'h4, cnt == 16);
            check_out($sformatf("stall_hold%0d", k), 4'h4, 4'h0);
            if (bus.ack !== 4'h0) acks++;
        end
        step(0, 4'h4, cnt == 16);
        check_out("stall_read", 4'h4, 4'h0);
        cnt--;
        step(0, 4'h4, cnt == 16);
        check_out("stall_one_ack", 4'h4, 4'h4);
        if (bus.ack !== 4'h0) acks++;
        if (bus.fifo_write === 1'b1) cnt++;
        step(0, 4'h4, cnt == 16);
        check_out("stall_refull", 4'h4, 4'h0);
        if (bus.ack !== 4'h0) acks++;
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL stall_ack_count: got %0d acks, want 1", acks);
        end
        step(0, 4'h0, 1);
        check_out("stall_release", 4'h4, 4'h0);

        // Single requester: pointer sits at 3, producer 0 wins and streams
        step(0, 4'h1, 0);
        check_out("single_idle", 4'h0, 4'h0);
        words = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 4'h1, 0);
            check_out($sformatf("single_beat%0d", k), 4'h1, 4'h1);
            if (bus.fifo_write === 1'b1) words++;
        end
        checks++;
        if (words != 10) begin
            errors++;
            $display("FAIL single_words: got %0d words, want 10", words);
        end
        step(0, 4'h0, 0);
        check_out("single_drop", 4'h1, 4'h0);

        // Reset on beat 2 of producer 2's burst; order restarts at producer 0
        step(0, 4'h4, 0);
        check_out("rstmid_idle", 4'h0, 4'h0);
        step(0, 4'h4, 0);
        check_out("rstmid_beat1", 4'h4, 4'h4);
        step(1, 4'h4, 0);
        check_out("rstmid_beat2", 4'h4, 4'h4);
        step(0, 4'hF, 0);
        check_out("rstmid_after", 4'h0, 4'h0);
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (stat_words !== '0 || stat_stall !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_stats: got words=%h stall=%h, want 0 and 0", stat_words, stat_stall);
        end
`endif
        step(0, 4'hF, 0);
        check_out("rstmid_regrant", 4'h1, 4'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the 16-deep x 16-bit `fifo` write port between NUM_REQ producers. It grants one producer at a time for a bounded burst, muxes that producer's data onto `fifo_data_in`, and asserts `fifo_write` only when the FIFO is not full. It sits directly in front of `fifo`. The read side of `fifo` is untouched.

## Interface
- NUM_REQ, 4: number of producers (2..8).
- DATA_W, 16: data width; must match `fifo`.
- MAX_BURST, 4: maximum accepted words per grant (1..16).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-producer request; held high while that producer has data.
- req_data  in  NUM_REQ*DATA_W  producer data; slice i belongs to producer i.
- gnt  out  NUM_REQ  registered one-hot grant (all-zero when idle).
- ack  out  NUM_REQ  combinational accept; the word on slice i is consumed this cycle.
- fifo_full  in  1  from `fifo`.
- fifo_write  out  1  to `fifo`.
- fifo_data_in  out  DATA_W  to `fifo`.
- busy  out  1  registered; high while in BURST.

## Operation
- States:
  - IDLE: `gnt` = 0.
  - BURST: `gnt` = one-hot owner `o`, plus beat counter `bc` of width clog2(MAX_BURST)+1.
- Accept rule: `ack[i] = gnt[i] & req[i] & ~fifo_full`, `fifo_write = |ack`, `fifo_data_in = req_data` slice of the owner. When `gnt` = 0, `fifo_data_in` = 0.
- Arbitration decisions:
  - Made at a clock edge in IDLE with any `req` high.
  - Also made at the edge where a burst ends.
  - Search starts at `rr_ptr` and wraps modulo NUM_REQ. The first requester found becomes the owner. `rr_ptr` <= owner+1, mod NUM_REQ.
- Burst end is evaluated at the edge and is true when either:
  - an accept occurs with `bc == MAX_BURST-1`, or
  - `req[o]` = 0.
- At burst end:
  - If another arbitration winner exists, the next state is BURST with the new owner and `bc` = 0. This is back-to-back with no bubble.
  - Otherwise the next state is IDLE.
  - The just-finished owner is eligible only after all others, by virtue of `rr_ptr`.
- `bc` increments only on an accepted beat.
- Full stall: while `fifo_full` = 1 the owner keeps `gnt`, `bc` holds, and `ack` = 0. There is no timeout.
- Owner drops `req` mid-burst: no accept that cycle. The burst ends at that edge.
- Single requester: after MAX_BURST beats it is re-granted immediately because no other requester is pending. Throughput stays at 1 word/cycle.
- Reset, including mid-burst:
  - `gnt` = 0, `busy` = 0, `bc` = 0, `rr_ptr` = 0, state IDLE.
  - Combinationally this gives `ack` = 0, `fifo_write` = 0, `fifo_data_in` = 0.
- The arbiter never asserts `fifo_write` while `fifo_full` = 1.

## Timing
- Arbitration latency: a `req` rising in IDLE gets `gnt` on the next edge. The first `ack` can occur in the cycle after that edge.
- Data path from `req_data` to `fifo_data_in` is combinational. `fifo` captures the data at the same edge where `ack` is high.
- `gnt` and `busy` change only on clock edges. `ack` and `fifo_write` follow `req`/`fifo_full` combinationally within the cycle.
- A burst of MAX_BURST words with no full stall occupies exactly MAX_BURST consecutive cycles.

## Configuration
- `FIFO_ARB_STATS_EN` defined adds these outputs:
  - `stat_words` (NUM_REQ*16): per-producer accepted-word counters.
  - `stat_stall` (16): cycles with `gnt != 0`, `req[o] = 1` and `fifo_full = 1`.
  - Every counter saturates at 16'hFFFF and clears on `rst`.
- `FIFO_ARB_STATS_EN` undefined: these ports and counters do not exist. Arbitration behaviour is identical.

## Test plan
- Reset: `rst` = 1 for 2 cycles with all `req` = 1 -> `gnt` = 0, `fifo_write` = 0, `busy` = 0 throughout. After release, `gnt` = 4'b0001 on the next edge.
- Round-robin: all 4 `req` high, data = 16'h1000+i, MAX_BURST = 4, `fifo` draining -> the FIFO receives 4x 0x1000, 4x 0x1001, 4x 0x1002, 4x 0x1003 in 16 consecutive cycles with no bubble.
- Full stall: fill `fifo` with 16 words from producer 2, then hold `req[2]` -> `ack` = 0, `fifo_write` = 0, `gnt` = 4'b0100 held. A single read frees a slot, giving exactly one `ack` on the following cycle.
- Early release: producer 1 requests for 2 beats then drops `req`, while producer 3 is pending -> `gnt` goes 4'b0010 -> 4'b1000 at the edge of the drop. Producer 3 gets 4 beats.
- Single requester: only `req[0]` held for 10 cycles after the grant -> 10 accepted words at 1 word/cycle, and `gnt[0]` is never deasserted.
- Reset mid-burst: assert `rst` on beat 2 of producer 2's burst -> `gnt` = 0 the next cycle. After release, the grant order restarts at producer 0. With `FIFO_ARB_STATS_EN`, all counters read 0.
